// File: rtl/dcache_assoc.sv
// Set-associative write-back, write-allocate data cache with AXI refill/write-back and MakeInvalid snoops.
// Optional macro DCACHE_PLRU_EN swaps per-set round-robin replacement for tree pseudo-LRU.
module dcache_assoc #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int WAYS       = 4,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [1:0]            wlen,
    input  logic                  dcache_enable,
    input  logic                  wrn,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  dcache_valid,
    output logic                  write_done,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic                  m_axi_bvalid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic                  m_axi_acvalid,
    output logic                  m_axi_acready,
    input  logic [ADDR_WIDTH-1:0] m_axi_acaddr,
    input  logic [3:0]            m_axi_acsnoop
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int NWAY  = 1 << WAY_W;
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 3;
    localparam int WA_W  = WAY_W + IDX_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:3]   addr_reg;
    logic [WAY_W-1:0]        victim_reg;
    logic [OFF_W-1:0]        cnt_reg;
    logic [SETS-1:0]         valid_reg [NWAY];
    logic [SETS-1:0]         dirty_reg [NWAY];
    logic [TAG_W-1:0]        tag_mem   [NWAY][SETS];
    logic [DATA_WIDTH-1:0]   data_mem  [1 << WA_W];
`ifdef DCACHE_PLRU_EN
    logic [NWAY-1:0]         plru_reg  [SETS];
`else
    logic [WAY_W-1:0]        rr_reg    [SETS];
`endif

    logic [OFF_W-1:0] req_off, lat_off;
    logic [IDX_W-1:0] req_idx, lat_idx, ac_idx;
    logic [TAG_W-1:0] req_tag, lat_tag, ac_tag;
    assign req_off = addr[OFF_W+2:3];
    assign req_idx = addr[OFF_W+3 +: IDX_W];
    assign req_tag = addr[ADDR_WIDTH-1 -: TAG_W];
    assign lat_off = addr_reg[OFF_W+2:3];
    assign lat_idx = addr_reg[OFF_W+3 +: IDX_W];
    assign lat_tag = addr_reg[ADDR_WIDTH-1 -: TAG_W];
    assign ac_idx  = m_axi_acaddr[OFF_W+3 +: IDX_W];
    assign ac_tag  = m_axi_acaddr[ADDR_WIDTH-1 -: TAG_W];

    logic [NWAY-1:0]  hit_vec;
    logic [WAY_W-1:0] hit_way, inv_way, repl_way, victim_next;
    logic             has_inv, lookup, hit;

    for (genvar gi = 0; gi < NWAY; gi++) begin : g_tag_cmp
        assign hit_vec[gi] = valid_reg[gi][req_idx] && (tag_mem[gi][req_idx] == req_tag);
    end

    assign lookup = (state_reg == IDLE) && reset && dcache_enable && !m_axi_acvalid;
    assign hit    = lookup && (|hit_vec);

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        has_inv = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_way = WAY_W'(i);
            if (!valid_reg[i][req_idx]) begin
                inv_way = WAY_W'(i);
                has_inv = 1'b1;
            end
        end
    end

`ifdef DCACHE_PLRU_EN
    // Node n's bit names the subtree holding the pseudo-LRU way; level l steers on way bit l.
    function automatic logic [NWAY-1:0] plru_touch(input logic [NWAY-1:0] bits, input logic [WAY_W-1:0] way);
        logic [NWAY-1:0] t;
        int node;
        t = bits;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            t[node] = ~way[l];
            node = 2 * node + int'(way[l]);
        end
        return t;
    endfunction

    always_comb begin
        int node;
        logic b;
        repl_way = '0;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            b = plru_reg[req_idx][node];
            repl_way[l] = b;
            node = 2 * node + int'(b);
        end
    end
`else
    assign repl_way = rr_reg[req_idx];
`endif

    assign victim_next = has_inv ? inv_way : repl_way;

    // Store merge: size-aligned byte lane enables, then right-aligned data shifted into place.
    logic [2:0]            lane_lo;
    logic [7:0]            lane_be, lane_en;
    logic [DATA_WIDTH-1:0] wmask, merged;
    always_comb begin
        lane_lo = addr[2:0] & ~((3'd1 << wlen) - 3'd1);
        case (wlen)
            2'd0:    lane_be = 8'h01;
            2'd1:    lane_be = 8'h03;
            2'd2:    lane_be = 8'h0F;
            default: lane_be = 8'hFF;
        endcase
        lane_en = lane_be << lane_lo;
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_wmask
        assign wmask[gi*8 +: 8] = {8{lane_en[gi]}};
    end
    assign merged = (rdata & ~wmask) | ((wdata << {lane_lo, 3'b000}) & wmask);

    assign rdata         = data_mem[{hit_way, req_idx, req_off}];
    assign dcache_valid  = hit && !wrn;
    assign write_done    = hit && wrn;
    assign m_axi_awvalid = (state_reg == WB_ADDR);
    assign m_axi_awaddr  = {tag_mem[victim_reg][lat_idx], lat_idx, {(OFF_W + 3){1'b0}}};
    assign m_axi_wvalid  = (state_reg == WB_DATA);
    assign m_axi_wdata   = data_mem[{victim_reg, lat_idx, cnt_reg}];
    assign m_axi_wlast   = m_axi_wvalid && (cnt_reg == LAST_BEAT);
    assign m_axi_arvalid = (state_reg == RD_ADDR);
    assign m_axi_araddr  = {addr_reg, 3'b000};
    assign m_axi_rready  = (state_reg == RD_DATA);
    assign m_axi_acready = (state_reg == IDLE) && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            victim_reg <= '0;
            cnt_reg    <= '0;
            for (int i = 0; i < NWAY; i++) begin
                valid_reg[i] <= '0;
                dirty_reg[i] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
`ifdef DCACHE_PLRU_EN
                plru_reg[s] <= '0;
`else
                rr_reg[s] <= '0;
`endif
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (m_axi_acvalid) begin
                        if (m_axi_acsnoop == 4'hD) begin
                            for (int i = 0; i < WAYS; i++) begin
                                if (tag_mem[i][ac_idx] == ac_tag) begin
                                    valid_reg[i][ac_idx] <= 1'b0;
                                    dirty_reg[i][ac_idx] <= 1'b0;
                                end
                            end
                        end
                    end else if (hit) begin
                        if (wrn) dirty_reg[hit_way][req_idx] <= 1'b1;
`ifdef DCACHE_PLRU_EN
                        plru_reg[req_idx] <= plru_touch(plru_reg[req_idx], hit_way);
`endif
                    end else if (dcache_enable) begin
                        addr_reg   <= addr[ADDR_WIDTH-1:3];
                        victim_reg <= victim_next;
                        state_reg  <= (valid_reg[victim_next][req_idx] && dirty_reg[victim_next][req_idx])
                                      ? WB_ADDR : RD_ADDR;
                    end
                end
                WB_ADDR: if (m_axi_awready) begin
                    cnt_reg   <= '0;
                    state_reg <= WB_DATA;
                end
                WB_DATA: if (m_axi_wready) begin
                    cnt_reg <= cnt_reg + OFF_W'(1);
                    if (cnt_reg == LAST_BEAT) begin
                        dirty_reg[victim_reg][lat_idx] <= 1'b0;
                        state_reg <= WB_RESP;
                    end
                end
                WB_RESP: if (m_axi_bvalid) state_reg <= RD_ADDR;
                RD_ADDR: begin
                    valid_reg[victim_reg][lat_idx] <= 1'b0;
                    if (m_axi_arready) begin
                        cnt_reg   <= '0;
                        state_reg <= RD_DATA;
                    end
                end
                RD_DATA: if (m_axi_rvalid) begin
                    cnt_reg <= cnt_reg + OFF_W'(1);
                    if (cnt_reg == LAST_BEAT) begin
                        valid_reg[victim_reg][lat_idx] <= 1'b1;
                        dirty_reg[victim_reg][lat_idx] <= 1'b0;
`ifdef DCACHE_PLRU_EN
                        plru_reg[lat_idx] <= plru_touch(plru_reg[lat_idx], victim_reg);
`else
                        rr_reg[lat_idx] <= (WAYS == 1) ? '0 : rr_reg[lat_idx] + WAY_W'(1);
`endif
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Line storage has no reset; the valid bits alone define what the cache holds.
    always_ff @(posedge clk) begin
        if (hit && wrn) data_mem[{hit_way, req_idx, req_off}] <= merged;
        if (state_reg == RD_ADDR) tag_mem[victim_reg][lat_idx] <= lat_tag;
        if (state_reg == RD_DATA && m_axi_rvalid)
            data_mem[{victim_reg, lat_idx, lat_off + cnt_reg}] <= m_axi_rdata;
    end
endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
- Set-associative, write-back, write-allocate data cache; parametrised successor of the direct-mapped pipeline D-cache.
- Sits between the memory stage and the AXI interconnect.
- Adds configurable ways, sets and line length, per-set victim selection, B-channel completion wait, and critical-word-first refill.

Parameters:
ADDR_WIDTH, 64, address width in bits
DATA_WIDTH, 64, word/beat width; must be 64
WAYS, 4, associativity; power of two, 1..8
SETS, 64, sets; power of two
LINE_WORDS, 8, words per line (AXI burst length); power of two, 2..16

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
addr  in  ADDR_WIDTH  request address
wdata  in  64  store data, right-aligned
wlen  in  2  store size, 2^wlen bytes
dcache_enable  in  1  request valid
wrn  in  1  1=write, 0=read
rdata  out  64  full aligned word at addr
dcache_valid  out  1  read hit, rdata valid this cycle
write_done  out  1  write hit, committed at this clock edge
m_axi_awaddr  out  ADDR_WIDTH  write-back line base
m_axi_awvalid  out  1  AW valid
m_axi_awready  in  1  AW ready
m_axi_wdata  out  64  write-back beat
m_axi_wlast  out  1  last write-back beat
m_axi_wvalid  out  1  W valid
m_axi_wready  in  1  W ready
m_axi_bvalid  in  1  write response valid; bready tied high at top level
m_axi_araddr  out  ADDR_WIDTH  refill address, word-aligned missing word
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rdata  in  64  refill beat
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axi_acvalid  in  1  snoop valid
m_axi_acready  out  1  snoop accepted
m_axi_acaddr  in  ADDR_WIDTH  snoop address
m_axi_acsnoop  in  4  snoop type

Behaviour:
- **Address split:** offset = addr[log2(LINE_WORDS)+2:3]; index = next log2(SETS) bits; tag = remaining upper bits.
- **Reset:** reset low immediately forces IDLE and clears all valid, dirty and replacement state. While reset is low:
  - awvalid, wvalid, arvalid, rready, acready, dcache_valid and write_done are 0.
  - Any in-flight AXI transaction is abandoned.
- **Hit:** tag matches a valid way in the set. Hit is combinational in IDLE only and never asserted while acvalid is high.
  - Read hit: dcache_valid=1 and rdata=word from the hitting way.
  - Write hit: write_done=1; at the same edge, merge bytes by wlen (byte/half/word/dword at addr low bits; low bits below the access size are ignored) and set dirty.
- **States:** IDLE, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA.
- **IDLE:** acready=1.
  - If acvalid: handle snoop; no request is serviced that cycle.
  - Else if dcache_enable and miss: latch addr and choose the victim.
    - Victim: lowest-numbered invalid way, else the replacement pointer's way.
    - Dirty victim goes to WB_ADDR, else RD_ADDR.
- **WB_ADDR:** awvalid=1 with awaddr={victim tag, index, 0}; on awready go to WB_DATA with beat counter=0.
- **WB_DATA:** wvalid=1 and wdata=victim word[counter]; wlast when counter=LINE_WORDS-1.
  - Counter advances on wready.
  - On the last beat with wready: clear dirty and go to WB_RESP.
- **WB_RESP:** wait for bvalid, then go to RD_ADDR. bresp is ignored.
- **RD_ADDR:** victim valid=0, tag written; arvalid=1; araddr = latched addr with the low 3 bits zeroed (wrap burst). On arready go to RD_DATA.
- **RD_DATA:** rready=1.
  - Each rvalid beat writes to word offset (start+n) mod LINE_WORDS, with wrap-around inside the line.
  - After LINE_WORDS beats: set valid and update replacement state, then return to IDLE. rlast is not used.
  - The request is then re-evaluated in IDLE and hits.
- **Replacement (default):** per-set round-robin pointer, incremented mod WAYS on every refill of that set.
- **Snoop:** acsnoop=4'hD (MakeInvalid) clears valid and dirty of every way in the indexed set whose tag matches, with no write-back. Other snoop codes are accepted with no effect.
- **Simultaneous events:** a snoop and a request in the same IDLE cycle go to the snoop. A snoop arriving outside IDLE stalls (acready=0).

Optional Feature:
- DCACHE_PLRU_EN defined: per-set tree pseudo-LRU (WAYS-1 bits) replaces round-robin.
  - Updated on every hit and every refill.
  - Victim = PLRU way when no invalid way exists.
- Undefined: round-robin as above; hits do not alter replacement state.

Test Plan:
1. Cold read 0x1028 -> arvalid with araddr=0x1028; 8 beats 0xA0..0xA7 land at offsets 5,6,7,0..4; re-read hits returning 0xA0 with no further AR.
2. Write hit sb 0xFF to 0x1029 over word 0x1111111111111111 -> write_done=1 same cycle; read gives 0x111111111111FF11; line dirty.
3. WAYS=4: fill 5 distinct tags in set 0 with the first dirty -> 5th miss issues AW at the first line's base, 8 W beats, wlast on beat 8, waits for bvalid, then AR.
4. Snoop acsnoop=0xD at a valid line while dcache_enable is high in IDLE -> dcache_valid=0 that cycle, line invalidated, next read misses.
5. Assert reset mid-RD_DATA after 3 beats -> all valids 0 immediately; after release the same address misses again.
6. DCACHE_PLRU_EN, 4 ways: hit ways 0,1,2,3,0 then miss -> victim way 1; without the macro the victim is way 0.
